// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths and header field positions for the 1x3 router
package router_pkg;

   localparam int ROUTER_DATA_W      = 8;
   localparam int ROUTER_FIFO_DEPTH  = 16;
   localparam int ROUTER_FIFO_ADDR_W = 4;

   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   localparam int PKT_CNT_W = 7;

endpackage

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - 1W/1R register array with combinational read
// and a clear that drops only the header-marker (top) bit of every entry.
module router_fifo_mem #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 9,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Payload bits are never reset; a stale marker bit would fake a header.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i][WIDTH-1] <= 1'b0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-output packet FIFO with read-side packet length tracking.
// Optional sticky overflow/underflow flags under ROUTER_FIFO_ERR_FLAGS_EN.
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH  = ROUTER_FIFO_DEPTH,
   parameter int DATA_W = ROUTER_DATA_W,
   parameter int ADDR_W = ROUTER_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   ,
   output logic              err_ovf,
   output logic              err_udf
`endif
);

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [DATA_W-1:0]  data_out_q, data_out_d;
   logic [DATA_W:0]    rd_word;
   logic               flush;
   logic               wr_acc;
   logic               rd_acc;

   assign flush  = rst | soft_rst;
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign wr_acc = wr_en && !full && !flush;
   assign rd_acc = rd_en && !empty && !flush;

   router_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + 1),
      .ADDR_W(ADDR_W)
   ) u_mem (
      .clk    (clk),
      .clr_i  (flush),
      .we_i   (wr_acc),
      .waddr_i(wr_ptr_q[ADDR_W-1:0]),
      .wdata_i({lfd_state, data_in}),
      .raddr_i(rd_ptr_q[ADDR_W-1:0]),
      .rdata_o(rd_word)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pkt_cnt_d  = pkt_cnt_q;
      data_out_d = data_out_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         data_out_d = rd_word[DATA_W-1:0];
         // Header length field counts payload only; +1 covers the parity byte.
         if (rd_word[DATA_W]) begin
            pkt_cnt_d = PKT_CNT_W'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
         end else if (pkt_cnt_q != '0) begin
            pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
         end
      end else if (pkt_cnt_q == '0) begin
         data_out_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   logic err_ovf_q;
   logic err_udf_q;

   always_ff @(posedge clk) begin
      if (flush) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         if (wr_en && full) err_ovf_q <= 1'b1;
         if (rd_en && empty) err_udf_q <= 1'b1;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed and random stimulus against a queue-based packet FIFO model.
module tb_router_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       soft_rst = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
   logic       err_ovf;
   logic       err_udf;
`endif

   int total = 0;
   int bad = 0;

   bit [8:0]   m_q [$];
   int         m_cnt = 0;
   logic [7:0] m_dout = 8'h00;
   bit         m_ovf = 1'b0;
   bit         m_udf = 1'b0;

   always #5 clk = ~clk;

   router_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .soft_rst (soft_rst),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .lfd_state(lfd_state),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      ,
      .err_ovf  (err_ovf),
      .err_udf  (err_udf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cycle(input bit w, input bit r, input bit l, input logic [7:0] d,
                        input bit srst, input bit hrst, input string tag);
      bit       was_full;
      bit       was_empty;
      bit [8:0] head;
      rst = hrst; soft_rst = srst; wr_en = w; rd_en = r; lfd_state = l; data_in = d;
      if (hrst || srst) begin
         m_q.delete();
         m_cnt = 0; m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         was_full  = (m_q.size() == 16);
         was_empty = (m_q.size() == 0);
         if (w && was_full) m_ovf = 1'b1;
         if (r && was_empty) m_udf = 1'b1;
         if (r && !was_empty) begin
            head = m_q.pop_front();
            m_dout = head[7:0];
            if (head[8]) m_cnt = int'(head[7:2]) + 1;
            else if (m_cnt > 0) m_cnt--;
         end else if (m_cnt == 0) begin
            m_dout = 8'h00;
         end
         if (w && !was_full) m_q.push_back({l, d});
      end
      @(posedge clk);
      #1;
      check({tag, ".dout"}, data_out, m_dout);
      check({tag, ".full"}, full, m_q.size() == 16);
      check({tag, ".empty"}, empty, m_q.size() == 0);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
      check({tag, ".ovf"}, err_ovf, m_ovf);
      check({tag, ".udf"}, err_udf, m_udf);
`endif
   endtask

   task automatic wr(input bit l, input logic [7:0] d, input string tag);
      cycle(1'b1, 1'b0, l, d, 1'b0, 1'b0, tag);
   endtask

   task automatic rd(input string tag);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, tag);
   endtask

   task automatic hard_reset(input string tag);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, tag);
   endtask

   logic [7:0] pkt [5];

   initial begin
      pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h5A;

      hard_reset("reset");
      hard_reset("reset2");

      // Basic packet: header 0x0C announces 3 payload bytes plus parity.
      for (int i = 0; i < 5; i++) wr(i == 0, pkt[i], "pkt_wr");
      for (int i = 0; i < 5; i++) begin
         rd("pkt_rd");
         check("pkt_byte", data_out, pkt[i]);
      end
      idle("pkt_idle");
      check("pkt_zero", data_out, 8'h00);
      check("pkt_empty", empty, 1'b1);

      // Read on empty: ignored, sticky underflow flag when enabled.
      rd("udf");
      idle("udf_hold");
      wr(1'b0, 8'hA5, "udf_wr");
      rd("udf_rd");
      idle("udf_hold2");
      hard_reset("udf_clr");

      // Fill to full, then a write with a simultaneous read.
      for (int i = 0; i < 16; i++) wr(i == 0, 8'($urandom), "fill");
      check("full16", full, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, "ovf_rd");
      check("after_ovf_full", full, 1'b0);
      for (int i = 0; i < 16; i++) rd("drain");

      // Soft reset with a simultaneous write drops everything.
      for (int i = 0; i < 10; i++) wr(i == 0, 8'($urandom), "fill10");
      cycle(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, "soft_rst");
      check("srst_empty", empty, 1'b1);
      check("srst_full", full, 1'b0);
      check("srst_dout", data_out, 8'h00);
      rd("srst_rd");

      // Pointer wrap with three entries held in flight.
      for (int i = 0; i < 3; i++) wr(1'b0, 8'($urandom), "wrap_pre");
      for (int i = 0; i < 40; i++)
         cycle(1'b1, 1'b1, ($urandom_range(0, 7) == 0), 8'($urandom), 1'b0, 1'b0, "wrap");
      for (int i = 0; i < 4; i++) rd("wrap_drain");

      // Reset in the middle of a 20-byte packet (len field 18).
      hard_reset("mid_pre");
      wr(1'b1, 8'h48, "long_hdr");
      for (int i = 0; i < 15; i++) wr(1'b0, 8'($urandom), "long_wr");
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, "long_wrrd");
      for (int i = 0; i < 6; i++) rd("long_rd");
      hard_reset("mid_rst");
      check("mid_dout", data_out, 8'h00);
      check("mid_empty", empty, 1'b1);
      wr(1'b1, 8'h08, "re_hdr");
      wr(1'b0, 8'h91, "re_p0");
      wr(1'b0, 8'h92, "re_p1");
      wr(1'b0, 8'h93, "re_par");
      for (int i = 0; i < 4; i++) rd("re_rd");
      check("re_last", data_out, 8'h93);
      idle("re_idle");
      check("re_zero", data_out, 8'h00);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 5) == 0, 8'($urandom),
               $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0, "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-output-port packet FIFO of the 1x3 router. One instance per destination; three in total.
- Sits downstream of router_synchronizer:
  - wr_en[i] from the synchronizer drives the write enable.
  - soft_rst_i from the synchronizer drives the soft reset.
  - full/empty go back to the synchronizer as full_i/empty_i.
- Stores each byte with a header-marker bit. Tracks remaining packet length on the read side so the reading client sees exactly one packet's bytes.

Parameters:
- DEPTH, 16, number of entries (power of two).
- DATA_W, 8, payload byte width.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- soft_rst  input  1  synchronous flush from synchronizer timeout, active-high.
- wr_en  input  1  write request.
- rd_en  input  1  read request from output client.
- lfd_state  input  1  marks current write as a packet header byte.
- data_in  input  DATA_W  byte to store.
- data_out  output  DATA_W  registered read data.
- full  output  1  no free entry.
- empty  output  1  no stored entry.

Behaviour:
- Storage:
  - DEPTH x (DATA_W+1) array; bit DATA_W holds lfd_state captured at write.
  - Write/read pointers are ADDR_W+1 bits with a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low ADDR_W bits equal.
- Reset values (rst=1 or soft_rst=1): wr_ptr=0, rd_ptr=0, pkt_cnt=0, data_out=0, full=0, empty=1. All stored lfd bits are cleared. Payload contents are don't-care.
- Priority: rst > soft_rst > rd/wr. A write or read in the same cycle as soft_rst is dropped.
- Write: accepted iff wr_en && !full. Stores {lfd_state, data_in} at wr_ptr[ADDR_W-1:0], then wr_ptr increments.
  - A write while full is ignored, even with a simultaneous read. Pointers are unchanged and nothing is overwritten.
- Read: accepted iff rd_en && !empty. data_out <= mem[rd_ptr][DATA_W-1:0] at the next rising edge (1-cycle latency), then rd_ptr increments.
  - A read while empty is ignored. data_out holds.
- Simultaneous accepted read and write: both pointers advance; occupancy is unchanged.
- Packet counter (7 bits):
  - On an accepted read of an entry with lfd bit = 1: pkt_cnt <= data[7:2] + 1, covering payload length plus parity byte.
  - On an accepted read with lfd = 0 and pkt_cnt > 0: pkt_cnt decrements.
  - When pkt_cnt == 0 and no read is accepted: data_out <= 0 on the next edge. The bus idles at zero between packets.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 naturally. full/empty stay correct across the wrap.
- Reset mid-packet: all packet state is discarded. The next readable byte must be a header for pkt_cnt to reload.

Optional Feature:
- Macro ROUTER_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs err_ovf and err_udf (1 bit each, sticky, reset to 0 by rst or soft_rst).
  - err_ovf sets on wr_en && full.
  - err_udf sets on rd_en && empty.
- Not defined: the ports and logic are absent. Attempted overflow/underflow is silently ignored as described above.

Decomposition:
- Shared package router_pkg:
  - ROUTER_DATA_W = 8, ROUTER_FIFO_DEPTH = 16, ROUTER_FIFO_ADDR_W = 4.
  - Header field constants: HDR_LEN_MSB = 7, HDR_LEN_LSB = 2, HDR_ADDR_MSB = 1, HDR_ADDR_LSB = 0.
  - Packet length counter width PKT_CNT_W = 7.
- One natural sub-module: router_fifo_mem, a simple 1W/1R register array with write port, read address and combinational read data. Pointer, flag and counter logic stay in router_fifo.

Test Plan:
- Reset, then write header 0x0C (lfd=1) plus payload 0x11, 0x22, 0x33 and parity 0x5A, then read 5 times:
  - data_out shows 0x0C, 0x11, 0x22, 0x33, 0x5A, each 1 cycle after rd_en.
  - pkt_cnt hits 0; data_out returns to 0x00 the cycle after; empty=1.
- Write 16 bytes without reading:
  - full=1 after the 16th write.
  - A 17th write with simultaneous read does not store; occupancy drops to 15.
  - With ROUTER_FIFO_ERR_FLAGS_EN defined, err_ovf=1.
- Fill 10 bytes, then assert soft_rst for 1 cycle together with wr_en:
  - empty=1, full=0, data_out=0 next cycle; the write is dropped.
- Pointer wrap: repeat 40 write/read pairs, 3 entries deep:
  - Data order is preserved; empty/full never false-assert across the wrap.
- rd_en on empty FIFO after reset:
  - data_out stays 0, rd_ptr unchanged.
  - With ROUTER_FIFO_ERR_FLAGS_EN defined, err_udf=1 and holds until rst.
- Assert rst mid-read of a 20-byte packet:
  - All outputs return to reset values on the next edge; the next header read reloads pkt_cnt correctly.
